// File: rtl/spk_arb_pkg.sv
// ============================================================================
// Module      : spk_arb_pkg
// Description : Shared constants, FSM state encoding and sample type for the
//               speaker arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package spk_arb_pkg;

    localparam int FRAME_LEN  = 256;
    localparam int GAP_FRAMES = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    typedef logic signed [15:0] sample_t;

endpackage

`default_nettype wire

// File: rtl/spk_frame_timer.sv
// ============================================================================
// Module      : spk_frame_timer
// Description : Free-running frame counter; frame_tick marks the last cycle
//               of each codec frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module spk_frame_timer
    import spk_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    output logic frame_tick
);

    localparam int CNT_W = $clog2(FRAME_LEN);

    logic [CNT_W-1:0] count;

    // Counter width matches the frame length, so wrap is the natural rollover.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign frame_tick = (count == CNT_W'(FRAME_LEN - 1));

endmodule

`default_nettype wire

// File: rtl/speaker_arbiter.sv
// ============================================================================
// Module      : speaker_arbiter
// Description : Frame-synchronous two-source speaker arbiter (alarm beats
//               music) with a silent gap between owners. Optional macro
//               SPEAKER_ARBITER_VOLUME_SHIFT_EN adds the vol attenuation port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module speaker_arbiter
    import spk_arb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req,
`ifdef SPEAKER_ARBITER_VOLUME_SHIFT_EN
    input  logic [1:0]  vol,
`endif
    input  logic [15:0] src0_left,
    input  logic [15:0] src0_right,
    input  logic [15:0] src1_left,
    input  logic [15:0] src1_right,
    output logic [1:0]  grant,
    output logic [1:0]  take,
    output logic [15:0] audio_left,
    output logic [15:0] audio_right,
    output logic        busy
);

    localparam int GAP_W = $clog2(GAP_FRAMES + 1);

    logic             frame_tick;
    state_t           state, next_state;
    logic             owner, next_owner;
    logic [GAP_W-1:0] gap_cnt, next_gap_cnt;
    logic             pick_play, pick_owner;
    sample_t          sel_left, sel_right;
    logic [1:0]       next_grant, next_take;
    logic [15:0]      next_left, next_right;

    spk_frame_timer u_frame_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner   <= 1'b0;
            gap_cnt <= '0;
        end else begin
            state   <= next_state;
            owner   <= next_owner;
            gap_cnt <= next_gap_cnt;
        end
    end

    // Fresh selection used from IDLE and at the end of a gap; alarm wins ties.
    always_comb begin
        pick_play  = req[1] | req[0];
        pick_owner = req[1];
    end

    // Next-state logic; decisions only happen on the frame tick.
    always_comb begin
        next_state   = state;
        next_owner   = owner;
        next_gap_cnt = gap_cnt;
        if (frame_tick) begin
            case (state)
                IDLE: begin
                    next_state = pick_play ? PLAY : IDLE;
                    if (pick_play) next_owner = pick_owner;
                end
                PLAY: begin
                    if (!req[owner] || (!owner && req[1])) begin
                        next_state   = GAP;
                        next_gap_cnt = '0;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_W'(GAP_FRAMES - 1)) begin
                        next_state = pick_play ? PLAY : IDLE;
                        if (pick_play) next_owner = pick_owner;
                    end else begin
                        next_gap_cnt = gap_cnt + 1'b1;
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        sel_left  = next_owner ? sample_t'(src1_left)  : sample_t'(src0_left);
        sel_right = next_owner ? sample_t'(src1_right) : sample_t'(src0_right);
`ifdef SPEAKER_ARBITER_VOLUME_SHIFT_EN
        sel_left  = sel_left  >>> vol;
        sel_right = sel_right >>> vol;
`endif
    end

    // Output logic: take is a single-cycle pulse, everything else holds.
    always_comb begin
        next_grant = grant;
        next_take  = 2'b00;
        next_left  = audio_left;
        next_right = audio_right;
        if (frame_tick) begin
            if (next_state == PLAY) begin
                next_grant = {next_owner, ~next_owner};
                next_take  = {next_owner, ~next_owner};
                next_left  = sel_left;
                next_right = sel_right;
            end else begin
                next_grant = 2'b00;
                next_left  = 16'h0000;
                next_right = 16'h0000;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant       <= 2'b00;
            take        <= 2'b00;
            audio_left  <= 16'h0000;
            audio_right <= 16'h0000;
        end else begin
            grant       <= next_grant;
            take        <= next_take;
            audio_left  <= next_left;
            audio_right <= next_right;
        end
    end

    assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_speaker_arbiter.sv
// ============================================================================
// Module      : tb_speaker_arbiter
// Description : Scoreboard bench for speaker_arbiter with a frame-level
//               reference model; honours SPEAKER_ARBITER_VOLUME_SHIFT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_speaker_arbiter;

    typedef struct {
        logic [1:0]  grant;
        logic [1:0]  take;
        logic [15:0] left;
        logic [15:0] right;
        logic        busy;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [15:0] src0_left = 16'h0, src0_right = 16'h0;
    logic [15:0] src1_left = 16'h0, src1_right = 16'h0;
    logic [1:0]  grant, take;
    logic [15:0] audio_left, audio_right;
    logic        busy;
`ifdef SPEAKER_ARBITER_VOLUME_SHIFT_EN
    logic [1:0]  vol = 2'd0;
`endif

    int tests = 0;
    int fails = 0;
    exp_t q[$];
    exp_t cur;

    speaker_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
`ifdef SPEAKER_ARBITER_VOLUME_SHIFT_EN
        .vol         (vol),
`endif
        .src0_left   (src0_left),
        .src0_right  (src0_right),
        .src1_left   (src1_left),
        .src1_right  (src1_right),
        .grant       (grant),
        .take        (take),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t zero_exp();
        exp_t e;
        e.grant = 2'b00; e.take = 2'b00; e.left = 16'h0; e.right = 16'h0; e.busy = 1'b0;
        return e;
    endfunction

    function automatic logic [15:0] shaped(input logic [15:0] s);
        logic signed [15:0] t;
        t = s;
`ifdef SPEAKER_ARBITER_VOLUME_SHIFT_EN
        t = t >>> vol;
`endif
        return t;
    endfunction

    task automatic check_out(input string name, input exp_t e);
        tests++;
        if (grant !== e.grant || take !== e.take || audio_left !== e.left ||
            audio_right !== e.right || busy !== e.busy) begin
            fails++;
            if (fails <= 30)
                $display("FAIL %s @%0t: got grant=%b take=%b L=%h R=%h busy=%b, want grant=%b take=%b L=%h R=%h busy=%b",
                         name, $time, grant, take, audio_left, audio_right, busy,
                         e.grant, e.take, e.left, e.right, e.busy);
        end
    endtask

    // Reference model: one decision per 256-cycle frame, from the priority rules.
    initial begin : model
        int fc;
        int mode;       // 0 = silent/idle, 1 = playing, 2 = gap
        int own;
        int gap_left;
        exp_t e;
        fc = 0; mode = 0; own = 0; gap_left = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                fc = 0; mode = 0; own = 0; gap_left = 0;
                q.delete();
            end else begin
                if (fc == 255) begin
                    if (mode == 1) begin
                        if (req[own] == 1'b0 || (own == 0 && req[1])) begin
                            mode = 2;
                            gap_left = 2;
                        end
                    end else if (mode == 2) begin
                        gap_left = gap_left - 1;
                    end
                    if (mode == 0 || (mode == 2 && gap_left == 0)) begin
                        if (req[1]) begin mode = 1; own = 1; end
                        else if (req[0]) begin mode = 1; own = 0; end
                        else mode = 0;
                    end
                    e = zero_exp();
                    e.busy = (mode != 0);
                    if (mode == 1) begin
                        e.grant = (own == 1) ? 2'b10 : 2'b01;
                        e.take  = e.grant;
                        e.left  = shaped(own == 1 ? src1_left  : src0_left);
                        e.right = shaped(own == 1 ? src1_right : src0_right);
                    end
                    q.push_back(e);
                end
                fc = (fc + 1) % 256;
            end
        end
    end

    // Monitor: frame results are popped right after their tick; otherwise outputs must hold.
    initial begin : monitor
        exp_t e;
        cur = zero_exp();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cur = zero_exp();
            end else if (q.size() > 0) begin
                e = q.pop_front();
                check_out("frame_update", e);
                cur = e;
                cur.take = 2'b00;
            end else begin
                check_out("hold", cur);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frames(input int n);
        cyc(256 * n);
    endtask

    initial begin : stimulus
        cyc(3);
        check_out("reset_state", zero_exp());
        rst_n = 1'b1;

        // Music alone.
        req = 2'b01; src0_left = 16'h1234; src0_right = 16'h5678;
        src1_left = 16'h7FFF; src1_right = 16'h8000;
        frames(3);
`ifdef SPEAKER_ARBITER_VOLUME_SHIFT_EN
        vol = 2'd2; src0_left = 16'h8000;
        frames(2);
        vol = 2'd0;
        frames(1);
        src0_left = 16'h1234;
`endif
        // Alarm preempts music.
        req = 2'b11;
        frames(4);
        // Alarm releases, music returns after the gap.
        req = 2'b01;
        frames(4);
        // Both from idle: alarm wins.
        req = 2'b00;
        frames(4);
        req = 2'b11;
        frames(2);
        req = 2'b01;
        frames(4);
        // Short request pulse away from the tick.
        req = 2'b00;
        frames(4);
        cyc(100);
        req = 2'b01;
        cyc(10);
        req = 2'b00;
        frames(2);
        // Asynchronous reset mid-play.
        req = 2'b01;
        frames(2);
        cyc(50);
        #2 rst_n = 1'b0;
        #1 check_out("async_reset", zero_exp());
        cyc(3);
        rst_n = 1'b1;
        frames(3);
        // Randomised traffic.
        for (int i = 0; i < 160; i++) begin
            req        = 2'($urandom_range(0, 3));
            src0_left  = 16'($urandom); src0_right = 16'($urandom);
            src1_left  = 16'($urandom); src1_right = 16'($urandom);
`ifdef SPEAKER_ARBITER_VOLUME_SHIFT_EN
            vol = 2'($urandom_range(0, 3));
`endif
            cyc(32 + 32 * (i % 3));
        end
        req = 2'b00;
        frames(4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/speaker_arbiter.md
SPEAKER_ARBITER -- requirements
Module: speaker_arbiter

Interface
REQ-001 SHALL have port clk  input  1  system clock, same clock that drives the codec path (frame = 256 clk cycles).
REQ-002 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port req  input  2  per-requester speaker request; req[1] alarm (high priority), req[0] music.
REQ-004 SHALL have ports src0_left, src0_right, src1_left, src1_right  input  16 each  signed PCM sample offered by each requester.
REQ-005 SHALL have port grant  output  2  one-hot owner indication, 2'b00 when no owner.
REQ-006 SHALL have port take  output  2  one-cycle pulse per requester: its offered sample was consumed.
REQ-007 SHALL have ports audio_left, audio_right  output  16 each  sample to the speaker serializer.
REQ-008 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-009 Under VOLUME_SHIFT_EN only, SHALL have port vol  input  2  attenuation, arithmetic right shift by vol.

Function
REQ-010 SHALL run an 8-bit free-running frame counter, incrementing every clk, wrapping 255->0; frame_tick is high in the cycle where counter==255.
REQ-011 All state, grant, take and audio updates SHALL occur only on the clk edge ending a frame_tick cycle; otherwise outputs hold.
REQ-012 FSM states SHALL be IDLE, PLAY, GAP; a 1-bit owner register qualifies PLAY.
REQ-013 IDLE at tick: req[1] -> PLAY owner 1; else req[0] -> PLAY owner 0; else stay IDLE; both set -> owner 1.
REQ-014 PLAY at tick: owner's req low -> GAP; owner 0 with req[1] high -> GAP (preemption); else stay PLAY; owner 1 never preempted.
REQ-015 Entering or remaining in PLAY at a tick SHALL latch owner's src sample into audio_left/right and pulse take[owner] for exactly the following cycle.
REQ-016 GAP SHALL drive audio 16'h0000 for exactly GAP_FRAMES (2) complete frames, then at the next tick apply the IDLE selection rule directly (no extra IDLE frame).
REQ-017 IDLE and GAP SHALL drive audio 16'h0000, grant 2'b00, take 2'b00.
REQ-018 grant SHALL equal one-hot(owner) in PLAY, registered, changing on the same edge as the state.
REQ-019 Request changes between ticks SHALL be ignored; only req sampled at tick matters.
REQ-020 req deassert and req[1] rise in same tick while owner 0 SHALL give GAP (single gap, not two).

Reset
REQ-021 rst_n low SHALL asynchronously force: state IDLE, owner 0, frame counter 0, gap counter 0, grant 2'b00, take 2'b00, audio_left/right 16'h0000, busy 0.
REQ-022 Reset mid-PLAY or mid-GAP SHALL abandon the frame; first decision after release is at counter==255 (256th cycle).

Configuration
REQ-023 Macro SPEAKER_ARBITER_VOLUME_SHIFT_EN defined: vol port exists; latched samples = source >>> vol (sign-preserving) before register.
REQ-024 Macro undefined: no vol port, samples latched unmodified; all other behaviour identical.

Structure
REQ-025 Package spk_arb_pkg SHALL hold FRAME_LEN=256, GAP_FRAMES=2, the state enum (IDLE, PLAY, GAP) and a sample typedef (signed 16-bit).
REQ-026 Sub-module spk_frame_timer SHALL contain the frame counter and produce frame_tick; FSM, owner, gap counter and output registers stay in speaker_arbiter.

Verification
REQ-027 req=2'b01, src0_left=16'h1234, src0_right=16'h5678 -> after first tick grant=01, audio=1234/5678, take[0] one pulse per 256 cycles.
REQ-028 In PLAY owner 0, assert req[1] with src1=16'h7FFF/16'h8000 -> 2 frames of zero audio, grant 00, then grant=10, audio=7FFF/8000.
REQ-029 req=2'b11 from IDLE -> owner 1 chosen; later drop req[1] keeping req[0] -> GAP 2 frames, then grant=01.
REQ-030 Pulse req[0] high for 10 cycles away from tick -> no grant, no take, audio stays 0000.
REQ-031 rst_n low for 3 cycles mid-PLAY -> all outputs 0 immediately; re-grant exactly 256 cycles after release.
REQ-032 With VOLUME_SHIFT_EN, vol=2, src0_left=16'h8000 -> audio_left=16'hE000; vol=0 -> 16'h8000.
